fpu_result_register: RTL and testbench

FPU_RESULT_REGISTER -- requirements
Module: fpu_result_register

---
 rtl/fpu_result_register.sv | 142 ++++++++++++++
 tb/tb_fpu_result_register.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fpu_result_register.sv
// Holds the FPU core result/flags for host readback, with a per-operation timeout and overrun tracking.
// Optional interrupt output enabled by defining FPU_RESULT_IRQ_EN; otherwise fpu_irq is tied low.
//
// state | meaning
// IDLE  | no operation pending, last result held
// BUSY  | waiting for fpu_result_valid or timeout
// DONE  | result held until host_read or a new doorbell
module fpu_result_register #(
  parameter int unsigned TMO_CYCLES = 200,
  parameter logic [31:0] TMO_NAN    = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fpu_rst_w,
  input  logic        fpu_doorbell_r_i,
  input  logic        fpu_result_valid,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  input  logic        host_read,
  output logic [31:0] fpu_result_r,
  output logic [4:0]  fpu_flags_r,
  output logic        fpu_busy,
  output logic        fpu_done,
  output logic        fpu_timeout,
  output logic        fpu_overrun,
  output logic        fpu_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  flg_q, flg_d;
  logic        tmo_q, tmo_d;
  logic        ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flg_d   = flg_q;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q;
    if (fpu_rst_w) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      res_d   = 32'h0000_0000;
      flg_d   = 5'd0;
      tmo_d   = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fpu_doorbell_r_i) begin
            state_d = BUSY;
            cnt_d   = 8'd0;
            tmo_d   = 1'b0;
            flg_d   = 5'd0;
          end
        end
        BUSY: begin
          // A result strobe on the timeout cycle takes precedence over the timeout.
          if (fpu_result_valid) begin
            state_d = DONE;
            res_d   = fpu_result;
            flg_d   = fpu_flags;
          end else if (cnt_q >= TMO_LAST) begin
            state_d = DONE;
            res_d   = TMO_NAN;
            flg_d   = 5'b10000;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DONE: begin
          if (fpu_doorbell_r_i) begin
            state_d = BUSY;
            cnt_d   = 8'd0;
            tmo_d   = 1'b0;
            flg_d   = 5'd0;
            ovr_d   = ~host_read;
          end else if (host_read) begin
            state_d = IDLE;
            ovr_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      res_q   <= 32'h0000_0000;
      flg_q   <= 5'd0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign fpu_result_r = res_q;
  assign fpu_flags_r  = flg_q;
  assign fpu_busy     = (state_q == BUSY);
  assign fpu_done     = (state_q == DONE);
  assign fpu_timeout  = tmo_q;
  assign fpu_overrun  = ovr_q;

`ifdef FPU_RESULT_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (state_d == DONE) | ovr_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign fpu_irq = irq_q;
`else
  assign fpu_irq = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_result_register.sv
// Directed plus randomized bench for fpu_result_register with a cycle-count based reference model.
module tb_fpu_result_register;

  localparam int TMO = 8;
  localparam logic [31:0] NAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fpu_rst_w, fpu_doorbell_r_i, fpu_result_valid, host_read;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic [31:0] fpu_result_r;
  logic [4:0]  fpu_flags_r;
  logic        fpu_busy, fpu_done, fpu_timeout, fpu_overrun, fpu_irq;

  fpu_result_register #(.TMO_CYCLES(TMO), .TMO_NAN(NAN)) dut (
    .clk(clk), .reset_n(reset_n), .fpu_rst_w(fpu_rst_w),
    .fpu_doorbell_r_i(fpu_doorbell_r_i), .fpu_result_valid(fpu_result_valid),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags), .host_read(host_read),
    .fpu_result_r(fpu_result_r), .fpu_flags_r(fpu_flags_r), .fpu_busy(fpu_busy),
    .fpu_done(fpu_done), .fpu_timeout(fpu_timeout), .fpu_overrun(fpu_overrun),
    .fpu_irq(fpu_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model: operation phase plus the cycle index at which it started.
  int          cyc = 0;
  int          start_cyc = 0;
  bit          m_busy, m_done, m_tmo, m_ovr;
  logic [31:0] m_res;
  logic [4:0]  m_flg;

  function automatic void model_clear();
    m_busy = 0; m_done = 0; m_tmo = 0; m_ovr = 0; m_res = '0; m_flg = '0;
  endfunction

  function automatic void begin_op();
    m_busy = 1; m_done = 0; m_tmo = 0; m_flg = '0; start_cyc = cyc;
  endfunction

  function automatic void model_edge();
    cyc++;
    if (fpu_rst_w) model_clear();
    else if (!m_busy && !m_done) begin
      if (fpu_doorbell_r_i) begin_op();
    end else if (m_busy) begin
      if (fpu_result_valid) begin
        m_res = fpu_result; m_flg = fpu_flags; m_busy = 0; m_done = 1;
      end else if (cyc - start_cyc >= TMO) begin
        m_res = NAN; m_flg = 5'b10000; m_tmo = 1; m_busy = 0; m_done = 1;
      end
    end else begin
      if (fpu_doorbell_r_i) begin
        m_ovr = !host_read;
        begin_op();
      end else if (host_read) begin
        m_done = 0; m_ovr = 0;
      end
    end
  endfunction

  task automatic chk(string tag, string what, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s.%s got %h exp %h", tag, what, got, exp);
  endtask

  task automatic chk_all(string tag);
    bit exp_irq;
`ifdef FPU_RESULT_IRQ_EN
    exp_irq = m_done | m_ovr;
`else
    exp_irq = 0;
`endif
    chk(tag, "result", fpu_result_r, m_res);
    chk(tag, "flags", 32'(fpu_flags_r), 32'(m_flg));
    chk(tag, "busy", 32'(fpu_busy), 32'(m_busy));
    chk(tag, "done", 32'(fpu_done), 32'(m_done));
    chk(tag, "timeout", 32'(fpu_timeout), 32'(m_tmo));
    chk(tag, "overrun", 32'(fpu_overrun), 32'(m_ovr));
    chk(tag, "irq", 32'(fpu_irq), 32'(exp_irq));
  endtask

  task automatic step(string tag, bit rw, bit db, bit v, logic [31:0] r, logic [4:0] f, bit hr);
    fpu_rst_w = rw; fpu_doorbell_r_i = db; fpu_result_valid = v;
    fpu_result = r; fpu_flags = f; host_read = hr;
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
    fpu_rst_w = 0; fpu_doorbell_r_i = 0; fpu_result_valid = 0; host_read = 0;
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 32'hDEAD_BEEF, 5'b11111, 0);
  endtask

  initial begin
    reset_n = 0;
    fpu_rst_w = 0; fpu_doorbell_r_i = 0; fpu_result_valid = 0; host_read = 0;
    fpu_result = '0; fpu_flags = '0;
    model_clear();
    #2;
    chk_all("reset");
    @(negedge clk);
    reset_n = 1;

    // Normal operation: valid 3 cycles after the doorbell.
    step("db1", 0, 1, 0, 0, 0, 0);
    idle("wait1", 2);
    step("cap1", 0, 0, 1, 32'h4049_0FDB, 5'b00001, 0);
    step("rd1", 0, 0, 0, 0, 0, 1);
    step("ign_valid_idle", 0, 0, 1, 32'h1234_5678, 5'b00100, 1);

    // Timeout after TMO busy cycles, extra doorbells ignored while busy.
    step("db2", 0, 1, 0, 0, 0, 0);
    step("db_in_busy", 0, 1, 0, 0, 0, 1);
    idle("wait2", TMO - 2);
    idle("tmo2", 1);
    step("ign_valid_done", 0, 0, 1, 32'h1111_1111, 5'b00011, 0);

    // Overrun, then doorbell with same-cycle host_read.
    step("ovr_set", 0, 1, 0, 0, 0, 0);
    step("cap3", 0, 0, 1, 32'hC000_0000, 5'b00010, 0);
    step("ovr_clr", 0, 1, 0, 0, 0, 1);
    step("cap4", 0, 0, 1, 32'h4000_0000, 5'b00000, 0);
    step("rd4", 0, 0, 0, 0, 0, 1);

    // Valid on the exact timeout cycle wins.
    step("db5", 0, 1, 0, 0, 0, 0);
    idle("wait5", TMO - 1);
    step("race5", 0, 0, 1, 32'h3F80_0000, 5'b00000, 0);
    step("rd5", 0, 0, 0, 0, 0, 1);

    // Soft clear with doorbell while busy.
    step("db6", 0, 1, 0, 0, 0, 0);
    idle("wait6", 2);
    step("softclr", 1, 1, 0, 0, 0, 0);
    idle("after_clr", 1);

    // Async reset mid-busy; strobe in first cycle after release ignored.
    step("db7", 0, 1, 0, 0, 0, 0);
    step("cap7", 0, 0, 1, 32'h4248_0000, 5'b00001, 0);
    step("db7b", 0, 1, 0, 0, 0, 0);
    idle("wait7", 1);
    #2;
    reset_n = 0;
    #1;
    model_clear();
    chk_all("async_rst");
    @(negedge clk);
    reset_n = 1;
    step("post_rst_valid", 0, 0, 1, 32'h5555_5555, 5'b00101, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), $urandom, 5'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
